mux4_rr_scheduler: RTL and testbench

//   Round-robin scheduler that sits directly upstream of the 4-to-1 data mux.
//   It arbitrates among 4 requesting channels and drives the mux select.
//   It captures the mux output y (fed back on mux_y) into an output register.

---
 rtl/mux4_rr_scheduler.sv | 109 ++++++++++
 tb/tb_mux4_rr_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler in front of a 4-to-1 data mux.
// It grants one requesting channel, steers the mux select to it, captures the
// mux output into a one-word output register, and presents that word as a
// valid/ready stream.
module mux4_rr_scheduler #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_valid,
  output logic [3:0]        req_ready,
  output logic [1:0]        sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] sel_q;
  logic [1:0] gnt;
  logic       can_load;
  logic       load;

  // Grant: first requesting channel at or after ptr, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  // Load decision, one-hot accept strobe and mux select.
  always_comb begin
    can_load  = (state == EMPTY) || out_ready;
    load      = !rst && can_load && (|req_valid);
    req_ready = '0;
    if (load) begin
      req_ready[gnt] = 1'b1;
    end
    // sel follows the grant in a load cycle and otherwise holds the last grant,
    // so the mux input stays stable between loads.
    if (rst) begin
      sel = '0;
    end else if (load) begin
      sel = gnt;
    end else begin
      sel = sel_q;
    end
  end

  // Output register FSM: a load fills (or refills) the register; a pop with
  // nothing to load empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
      sel_q     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_ch    <= gnt;
            ptr       <= gnt + 2'd1;
            sel_q     <= gnt;
          end
        end
        FULL: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_ch    <= gnt;
            ptr       <= gnt + 2'd1;
            sel_q     <= gnt;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of the scheduler.
module tb_mux4_rr_scheduler;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [1:0]        sel;
  logic [DATA_W-1:0] mux_y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_ch;

  logic [DATA_W-1:0] d [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int                m_ptr;
  int                m_sel;
  bit                m_full;
  logic [DATA_W-1:0] m_data;
  int                m_ch;

  // Combinational outputs observed just before the edge, and their expectation
  logic [3:0] obs_rr;
  logic [1:0] obs_sel;
  logic [3:0] exp_rr;
  logic [1:0] exp_sel;
  int         last_gnt;

  always #5 clk = ~clk;

  // The mux the scheduler steers.
  always_comb mux_y = d[sel];

  mux4_rr_scheduler #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  function automatic int pick(input logic [3:0] rv, input int p);
    for (int k = 0; k < 4; k++) begin
      if (rv[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive inputs, record combinational outputs, advance the model.
  task automatic cycle(input logic [3:0] rv, input logic ory, input logic r);
    int  g;
    bit  ld;
    req_valid = rv;
    out_ready = ory;
    rst       = r;
    #1;
    g  = pick(rv, m_ptr);
    ld = !r && (!m_full || ory) && (g >= 0);
    last_gnt = ld ? g : -1;
    exp_rr  = ld ? (4'b0001 << g) : 4'b0000;
    exp_sel = r ? 2'd0 : (ld ? 2'(g) : 2'(m_sel));
    obs_rr  = req_ready;
    obs_sel = sel;
    @(posedge clk);
    if (r) begin
      m_full = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_sel = 0;
    end else if (ld) begin
      m_full = 1; m_data = d[g]; m_ch = g; m_ptr = (g + 1) % 4; m_sel = g;
    end else if (m_full && ory) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cycle(4'hF, 1'b1, 1'b1);
      n_cmp++;
      if ({obs_rr, obs_sel} !== {4'b0000, 2'd0}) begin
        n_bad++;
        $display("FAIL reset_comb: req_ready/sel=%b/%0d want 0000/0", obs_rr, obs_sel);
      end
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b0, 2'd0, 4'h0}) begin
        n_bad++;
        $display("FAIL reset_regs: valid/ch/data=%b/%0d/%h want 0/0/0", out_valid, out_ch, out_data);
      end
    end
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) d[i] = 4'(i + 8);
    for (int i = 0; i < 8; i++) begin
      cycle(4'hF, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'(i % 4), 4'((i % 4) + 8)}) begin
        n_bad++;
        $display("FAIL round_robin[%0d]: valid/ch/data=%b/%0d/%h want 1/%0d/%h",
                 i, out_valid, out_ch, out_data, i % 4, (i % 4) + 8);
      end
    end
  endtask

  task automatic test_single_channel;
    d[2] = 4'hA;
    cycle(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_rr, obs_sel} !== {4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL single_grant: req_ready/sel=%b/%0d want 0100/2", obs_rr, obs_sel);
    end
    n_cmp++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 4'hA, 2'd2}) begin
      n_bad++;
      $display("FAIL single_capture: valid/data/ch=%b/%h/%0d want 1/a/2", out_valid, out_data, out_ch);
    end
  endtask

  // Follows single_channel, so ptr is 3 here.
  task automatic test_wrap_skip;
    cycle(4'b0010, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_rr, out_ch} !== {4'b0010, 2'd1}) begin
      n_bad++;
      $display("FAIL wrap_grant: req_ready/out_ch=%b/%0d want 0010/1", obs_rr, out_ch);
    end
    cycle(4'hF, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_rr, out_ch} !== {4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL wrap_ptr: req_ready/out_ch=%b/%0d want 0100/2", obs_rr, out_ch);
    end
  endtask

  task automatic test_backpressure;
    cycle(4'b0000, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: out_valid=%b want 0", out_valid);
    end
    d[1] = 4'h5;
    cycle(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d[i] = 4'hC;
      cycle(4'hF, 1'b0, 1'b0);
      n_cmp++;
      if ({obs_rr, out_valid, out_data, out_ch} !== {4'b0000, 1'b1, 4'h5, 2'd1}) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: rr/valid/data/ch=%b/%b/%h/%0d want 0000/1/5/1",
                 i, obs_rr, out_valid, out_data, out_ch);
      end
    end
    cycle(4'hF, 1'b1, 1'b0);
    n_cmp++;
    if ({obs_rr, obs_sel, out_ch} !== {4'b0100, 2'd2, 2'd2}) begin
      n_bad++;
      $display("FAIL backpressure_release: rr/sel/ch=%b/%0d/%0d want 0100/2/2", obs_rr, obs_sel, out_ch);
    end
  endtask

  task automatic test_reset_mid;
    cycle(4'b1000, 1'b1, 1'b0);
    n_cmp++;
    if ({out_valid, out_ch} !== {1'b1, 2'd3}) begin
      n_bad++;
      $display("FAIL mid_setup: valid/ch=%b/%0d want 1/3", out_valid, out_ch);
    end
    cycle(4'hF, 1'b0, 1'b1);
    n_cmp++;
    if ({out_valid, obs_rr} !== {1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL mid_reset: valid/rr=%b/%b want 0/0000", out_valid, obs_rr);
    end
    cycle(4'hF, 1'b0, 1'b0);
    n_cmp++;
    if ({obs_rr, out_ch, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_restart: rr/ch/valid=%b/%0d/%b want 0001/0/1", obs_rr, out_ch, out_valid);
    end
  endtask

  task automatic test_random;
    logic [3:0] rv;
    logic       ory;
    logic       r;
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
      rv  = 4'($urandom);
      ory = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 39) == 0);
      cycle(rv, ory, r);
      n_cmp++;
      if ({obs_rr, obs_sel} !== {exp_rr, exp_sel}) begin
        n_bad++;
        $display("FAIL random_comb[%0d]: rr/sel=%b/%0d want %b/%0d", i, obs_rr, obs_sel, exp_rr, exp_sel);
      end
      n_cmp++;
      if ({out_valid, out_data, out_ch} !== {m_full, m_data, 2'(m_ch)}) begin
        n_bad++;
        $display("FAIL random_regs[%0d]: valid/data/ch=%b/%h/%0d want %b/%h/%0d",
                 i, out_valid, out_data, out_ch, m_full, m_data, m_ch);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    m_ptr = 0; m_sel = 0; m_full = 0; m_data = '0; m_ch = 0; last_gnt = -1;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single_channel();
    test_wrap_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
